// File: rtl/mat_mult_pkg.sv
// Shared types, defaults and width helpers for the sequential matrix multiplier.
// Saturation is selected by the MAT_MULT_SAT_EN macro in the top level.
package mat_mult_pkg;

    localparam int DEF_M_ROWS     = 4;
    localparam int DEF_K_DIM      = 4;
    localparam int DEF_N_COLS     = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int WIDE_W         = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef struct packed {
        logic                     clamped;
        logic signed [WIDE_W-1:0] val;
    } conv_t;

    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k);
    endfunction

    // Result lands sign-extended in the low ow bits of val.
    function automatic conv_t conv_out(
        input logic signed [WIDE_W-1:0] v,
        input int                       ow,
        input logic                     sat_en
    );
        conv_t                    r;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] wrapped;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = ~hi;
        wrapped = (v <<< (WIDE_W - ow)) >>> (WIDE_W - ow);
        r.clamped = 1'b0;
        r.val = wrapped;
        if (sat_en) begin
            if (v > hi) begin
                r.val = hi;
                r.clamped = 1'b1;
            end else if (v < lo) begin
                r.val = lo;
                r.clamped = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mat_mult_if.sv
// Start handshake, operand and result bundle for mat_mult_seq.
// The requester uses master, the multiplier uses slave.
interface mat_mult_if
    import mat_mult_pkg::*;
#(
    parameter int M_ROWS     = DEF_M_ROWS,
    parameter int K_DIM      = DEF_K_DIM,
    parameter int N_COLS     = DEF_N_COLS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
);

    logic enable_mult;
    logic signed [M_ROWS-1:0][K_DIM-1:0][DATA_WIDTH-1:0] mat1;
    logic signed [K_DIM-1:0][N_COLS-1:0][DATA_WIDTH-1:0] mat2;
    logic busy;
    logic mult_done;
    logic signed [M_ROWS-1:0][N_COLS-1:0][OUT_WIDTH-1:0] mat_out;
    logic sat_flag;

    modport master(
        output enable_mult, mat1, mat2,
        input  busy, mult_done, mat_out, sat_flag
    );

    modport slave(
        input  enable_mult, mat1, mat2,
        output busy, mult_done, mat_out, sat_flag
    );

endinterface

// File: rtl/mat_mult_mac.sv
// Signed multiply-accumulate; sum is acc plus the current product, and the
// accumulator restarts from zero after a load-result strobe.
module mat_mult_mac
    import mat_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_K_DIM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        en,
    input  logic                        load,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  sum
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    assign prod = a * b;
    assign sum  = acc_q + ACC_WIDTH'(prod);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= load ? '0 : sum;
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential signed matrix multiplier sharing one MAC over M*N*K cycles.
// Define MAT_MULT_SAT_EN to clamp results and report sat_flag.
module mat_mult_seq
    import mat_mult_pkg::*;
#(
    parameter int M_ROWS     = DEF_M_ROWS,
    parameter int K_DIM      = DEF_K_DIM,
    parameter int N_COLS     = DEF_N_COLS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input logic       clk,
    input logic       reset,
    mat_mult_if.slave bus
);

    localparam int ACC_W = acc_width(DATA_WIDTH, K_DIM);
    localparam int IW = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;
    localparam int JW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int KW = (K_DIM > 1) ? $clog2(K_DIM) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(M_ROWS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_COLS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K_DIM - 1);

`ifdef MAT_MULT_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t state_q;
    state_t state_d;

    logic signed [M_ROWS-1:0][K_DIM-1:0][DATA_WIDTH-1:0] a_q;
    logic signed [K_DIM-1:0][N_COLS-1:0][DATA_WIDTH-1:0] b_q;
    logic signed [M_ROWS-1:0][N_COLS-1:0][OUT_WIDTH-1:0] out_q;

    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [KW-1:0] k_q;

    logic last_k;
    logic last_j;
    logic last_elem;
    logic accept;
    logic step;
    logic busy;
    logic done;

    logic signed [ACC_W-1:0] mac_sum;
    conv_t                   conv;
    logic                    unused_bits;

    assign last_k    = (k_q == K_LAST);
    assign last_j    = (j_q == J_LAST);
    assign last_elem = last_k && last_j && (i_q == I_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable_mult) state_d = CALC;
            CALC:    if (last_elem) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): accept = bus.enable_mult;
            (state_q == CALC): begin
                step = 1'b1;
                busy = 1'b1;
            end
            (state_q == DONE): done = 1'b1;
            default: ;
        endcase
    end

    mat_mult_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_W)
    ) u_mac (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .en   (step),
        .load (last_k),
        .a    ($signed(a_q[i_q][k_q])),
        .b    ($signed(b_q[k_q][j_q])),
        .sum  (mac_sum)
    );

    assign conv = conv_out(WIDE_W'(mac_sum), OUT_WIDTH, SAT_EN);
    assign unused_bits = ^{conv.val[WIDE_W-1:OUT_WIDTH], conv.clamped};

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
        end else if (accept) begin
            a_q   <= bus.mat1;
            b_q   <= bus.mat2;
            out_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
        end else if (step) begin
            if (last_k) begin
                out_q[i_q][j_q] <= conv.val[OUT_WIDTH-1:0];
                k_q <= '0;
                if (last_j) begin
                    j_q <= '0;
                    i_q <= i_q + IW'(1);
                end else begin
                    j_q <= j_q + JW'(1);
                end
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

`ifdef MAT_MULT_SAT_EN
    logic sat_q;

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            sat_q <= 1'b0;
        end else if (step && last_k && conv.clamped) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    assign bus.sat_flag = 1'b0;
`endif

    assign bus.busy      = busy;
    assign bus.mult_done = done;
    assign bus.mat_out   = out_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed self-checking bench for mat_mult_seq (4x4, 2x3x1 and 1x4x1 with
// 8-bit results); expectations follow MAT_MULT_SAT_EN.
module tb_mat_mult_seq;
    import mat_mult_pkg::*;

    logic clk = 1'b0;
    logic rst4;
    logic rst2;
    logic rsts;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    mat_mult_if #(.M_ROWS(4), .K_DIM(4), .N_COLS(4),
                  .DATA_WIDTH(8), .OUT_WIDTH(16)) if4 ();
    mat_mult_if #(.M_ROWS(2), .K_DIM(3), .N_COLS(1),
                  .DATA_WIDTH(8), .OUT_WIDTH(16)) if2 ();
    mat_mult_if #(.M_ROWS(1), .K_DIM(4), .N_COLS(1),
                  .DATA_WIDTH(8), .OUT_WIDTH(8)) ifs ();

    mat_mult_seq #(.M_ROWS(4), .K_DIM(4), .N_COLS(4),
                   .DATA_WIDTH(8), .OUT_WIDTH(16)) u_sq (
        .clk(clk), .reset(rst4), .bus(if4));
    mat_mult_seq #(.M_ROWS(2), .K_DIM(3), .N_COLS(1),
                   .DATA_WIDTH(8), .OUT_WIDTH(16)) u_ns (
        .clk(clk), .reset(rst2), .bus(if2));
    mat_mult_seq #(.M_ROWS(1), .K_DIM(4), .N_COLS(1),
                   .DATA_WIDTH(8), .OUT_WIDTH(8)) u_st (
        .clk(clk), .reset(rsts), .bus(ifs));

    // A = B = row-major 0..15, so C[i][j] = 96i + 16ij + 56 + 6j
    function automatic int sq_ref(input int i, input int j);
        return 96 * i + 16 * i * j + 56 + 6 * j;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int which, input int cyc_in,
                             output int cyc_out);
        int c;
        c = cyc_in;
        cyc_out = -1;
        for (int n = 0; n < 300; n++) begin
            logic d;
            case (which)
                0:       d = if4.mult_done;
                1:       d = if2.mult_done;
                default: d = ifs.mult_done;
            endcase
            if (d) begin
                cyc_out = c;
                return;
            end
            tick();
            c++;
        end
    endtask

    task automatic load_seq4();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                if4.mat1[i][k] = 8'(4 * i + k);
                if4.mat2[i][k] = 8'(4 * i + k);
            end
    endtask

    task automatic test_reset();
        vec_cnt++;
        if (if4.busy !== 1'b0 || if4.mult_done !== 1'b0 ||
            if4.mat_out !== '0 || if4.sat_flag !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_4x4: busy=%b done=%b out=%h sat=%b",
                     if4.busy, if4.mult_done, if4.mat_out, if4.sat_flag);
        end
        vec_cnt++;
        if (if2.busy !== 1'b0 || if2.mat_out !== '0 ||
            ifs.busy !== 1'b0 || ifs.mat_out !== '0 ||
            ifs.sat_flag !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_small: busy2=%b out2=%h busys=%b outs=%h",
                     if2.busy, if2.mat_out, ifs.busy, ifs.mat_out);
        end
        rst4 = 1'b0;
        rst2 = 1'b0;
        rsts = 1'b0;
        tick();
        vec_cnt++;
        if (if4.busy !== 1'b0 || if4.mult_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: busy=%b done=%b required 0 0",
                     if4.busy, if4.mult_done);
        end
    endtask

    task automatic test_square();
        int c;
        int bc;
        load_seq4();
        if4.enable_mult = 1'b1;
        tick();
        if4.enable_mult = 1'b0;
        c  = 1;
        bc = 0;
        while (!if4.mult_done && c < 300) begin
            if (if4.busy) bc++;
            tick();
            c++;
        end
        vec_cnt++;
        if (c !== 65) begin
            err_cnt++;
            $display("FAIL sq_done_cycle: got %0d required 65", c);
        end
        vec_cnt++;
        if (bc !== 64) begin
            err_cnt++;
            $display("FAIL sq_busy_cycles: got %0d required 64", bc);
        end
        vec_cnt++;
        if (if4.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL sq_busy_at_done: got %b required 0", if4.busy);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vec_cnt++;
                if ($signed(if4.mat_out[i][j]) !== sq_ref(i, j)) begin
                    err_cnt++;
                    $display("FAIL sq_elem[%0d][%0d]: got %0d required %0d",
                             i, j, $signed(if4.mat_out[i][j]), sq_ref(i, j));
                end
            end
        vec_cnt++;
        if (if4.sat_flag !== 1'b0) begin
            err_cnt++;
            $display("FAIL sq_sat: got %b required 0", if4.sat_flag);
        end
        tick();
        vec_cnt++;
        if (if4.mult_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL sq_done_pulse: got %b required 0", if4.mult_done);
        end
        tick();
        tick();
        vec_cnt++;
        if ($signed(if4.mat_out[3][3]) !== 506) begin
            err_cnt++;
            $display("FAIL sq_hold: got %0d required 506",
                     $signed(if4.mat_out[3][3]));
        end
    endtask

    task automatic test_nonsquare();
        int c;
        if2.mat1[0][0] = 8'(1);
        if2.mat1[0][1] = 8'(-2);
        if2.mat1[0][2] = 8'(3);
        if2.mat1[1][0] = 8'(-4);
        if2.mat1[1][1] = 8'(5);
        if2.mat1[1][2] = 8'(-6);
        if2.mat2[0][0] = 8'(7);
        if2.mat2[1][0] = 8'(8);
        if2.mat2[2][0] = 8'(9);
        if2.enable_mult = 1'b1;
        tick();
        if2.enable_mult = 1'b0;
        wait_done(1, 1, c);
        vec_cnt++;
        if (c !== 7) begin
            err_cnt++;
            $display("FAIL ns_done_cycle: got %0d required 7", c);
        end
        vec_cnt++;
        if ($signed(if2.mat_out[0][0]) !== 18) begin
            err_cnt++;
            $display("FAIL ns_elem0: got %0d required 18",
                     $signed(if2.mat_out[0][0]));
        end
        vec_cnt++;
        if ($signed(if2.mat_out[1][0]) !== -42) begin
            err_cnt++;
            $display("FAIL ns_elem1: got %0d required -42",
                     $signed(if2.mat_out[1][0]));
        end
        tick();
    endtask

    task automatic test_saturation();
        int c;
        int exp_v;
        logic exp_s;
        for (int run = 0; run < 2; run++) begin
`ifdef MAT_MULT_SAT_EN
            exp_v = (run == 0) ? 127 : -128;
            exp_s = 1'b1;
`else
            exp_v = (run == 0) ? 4 : 0;
            exp_s = 1'b0;
`endif
            for (int k = 0; k < 4; k++) begin
                ifs.mat1[0][k] = (run == 0) ? 8'(127) : 8'(-128);
                ifs.mat2[k][0] = 8'(127);
            end
            ifs.enable_mult = 1'b1;
            tick();
            ifs.enable_mult = 1'b0;
            vec_cnt++;
            if (ifs.sat_flag !== 1'b0 || ifs.mat_out !== '0) begin
                err_cnt++;
                $display("FAIL sat_clear_run%0d: sat=%b out=%0d required 0 0",
                         run, ifs.sat_flag, $signed(ifs.mat_out[0][0]));
            end
            wait_done(2, 1, c);
            vec_cnt++;
            if (c !== 5) begin
                err_cnt++;
                $display("FAIL sat_done_run%0d: got %0d required 5", run, c);
            end
            vec_cnt++;
            if ($signed(ifs.mat_out[0][0]) !== exp_v) begin
                err_cnt++;
                $display("FAIL sat_val_run%0d: got %0d required %0d",
                         run, $signed(ifs.mat_out[0][0]), exp_v);
            end
            vec_cnt++;
            if (ifs.sat_flag !== exp_s) begin
                err_cnt++;
                $display("FAIL sat_flag_run%0d: got %b required %b",
                         run, ifs.sat_flag, exp_s);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int nz;
        int seen;
        load_seq4();
        if4.enable_mult = 1'b1;
        tick();
        if4.enable_mult = 1'b0;
        for (c = 1; c < 20; c++) tick();
        vec_cnt++;
        if ($signed(if4.mat_out[0][3]) !== 74 || if4.busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_pre_reset: elem=%0d busy=%b required 74 1",
                     $signed(if4.mat_out[0][3]), if4.busy);
        end
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        nz = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (if4.mat_out[i][j] !== '0) nz++;
        vec_cnt++;
        if (if4.busy !== 1'b0 || if4.mult_done !== 1'b0 || nz !== 0) begin
            err_cnt++;
            $display("FAIL mid_reset: busy=%b done=%b nonzero=%0d required 0 0 0",
                     if4.busy, if4.mult_done, nz);
        end
        seen = 0;
        for (int n = 0; n < 70; n++) begin
            if (if4.mult_done || if4.busy) seen++;
            tick();
        end
        vec_cnt++;
        if (seen !== 0) begin
            err_cnt++;
            $display("FAIL mid_no_done: active cycles=%0d required 0", seen);
        end
        rst4 = 1'b1;
        if4.enable_mult = 1'b1;
        tick();
        rst4 = 1'b0;
        if4.enable_mult = 1'b0;
        vec_cnt++;
        if (if4.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_vs_start: busy=%b required 0", if4.busy);
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                if4.mat1[i][k] = (i == k) ? 8'(1) : 8'(0);
                if4.mat2[i][k] = 8'(4 * i + k - 8);
            end
        if4.enable_mult = 1'b1;
        tick();
        if4.enable_mult = 1'b0;
        wait_done(0, 1, c);
        vec_cnt++;
        if (c !== 65) begin
            err_cnt++;
            $display("FAIL mid_restart_cycle: got %0d required 65", c);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vec_cnt++;
                if ($signed(if4.mat_out[i][j]) !== 4 * i + j - 8) begin
                    err_cnt++;
                    $display("FAIL mid_elem[%0d][%0d]: got %0d required %0d",
                             i, j, $signed(if4.mat_out[i][j]), 4 * i + j - 8);
                end
            end
        tick();
    endtask

    task automatic test_ignore_enable();
        int c;
        load_seq4();
        if4.enable_mult = 1'b1;
        tick();
        if4.enable_mult = 1'b0;
        for (c = 1; c < 10; c++) tick();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                if4.mat1[i][k] = 8'(1);
                if4.mat2[i][k] = 8'(-1);
            end
        if4.enable_mult = 1'b1;
        tick();
        c++;
        if4.enable_mult = 1'b0;
        wait_done(0, c, c);
        vec_cnt++;
        if (c !== 65) begin
            err_cnt++;
            $display("FAIL ign_done_cycle: got %0d required 65", c);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vec_cnt++;
                if ($signed(if4.mat_out[i][j]) !== sq_ref(i, j)) begin
                    err_cnt++;
                    $display("FAIL ign_elem[%0d][%0d]: got %0d required %0d",
                             i, j, $signed(if4.mat_out[i][j]), sq_ref(i, j));
                end
            end
        tick();
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                if4.mat1[i][k] = 8'(2);
                if4.mat2[i][k] = 8'(-3);
            end
        if4.enable_mult = 1'b1;
        tick();
        wait_done(0, 1, c1);
        tick();
        wait_done(0, c1 + 1, c2);
        if4.enable_mult = 1'b0;
        vec_cnt++;
        if (c1 !== 65) begin
            err_cnt++;
            $display("FAIL b2b_first: got %0d required 65", c1);
        end
        vec_cnt++;
        if (c2 - c1 !== 66) begin
            err_cnt++;
            $display("FAIL b2b_interval: got %0d required 66", c2 - c1);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vec_cnt++;
                if ($signed(if4.mat_out[i][j]) !== -24) begin
                    err_cnt++;
                    $display("FAIL b2b_elem[%0d][%0d]: got %0d required -24",
                             i, j, $signed(if4.mat_out[i][j]));
                end
            end
        tick();
        tick();
        tick();
        vec_cnt++;
        if (if4.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_stop: busy=%b required 0", if4.busy);
        end
    endtask

    initial begin
        rst4 = 1'b1;
        rst2 = 1'b1;
        rsts = 1'b1;
        if4.enable_mult = 1'b0;
        if2.enable_mult = 1'b0;
        ifs.enable_mult = 1'b0;
        if4.mat1 = '0;
        if4.mat2 = '0;
        if2.mat1 = '0;
        if2.mat2 = '0;
        ifs.mat1 = '0;
        ifs.mat2 = '0;
        tick();
        tick();
        tick();
        test_reset();
        test_square();
        test_nonsquare();
        test_saturation();
        test_reset_mid();
        test_ignore_enable();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
